alu_dispatch: RTL and testbench
===============================

# alu_dispatch

Two-stage issue/capture front end that drives the 32-bit ALU's operand and opcode inputs and collects its result and flags. Decode hands it operations over a valid/ready handshake. It registers each operation onto the ALU inputs, captures the combinational ALU output one cycle later, and presents tagged results to writeback with backpressure. It also owns the architectural carry flag, which the ALU updates only for ADD/SUB.

## Interface
- DATA_W, 32, operand/result width; must match the ALU.
- TAG_W, 5, destination-register tag width.

- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid from decode.
- in_ready  out  1  block can accept a request this cycle.
- in_op  in  4  ALU opcode: 0 NOP, 1 AND, 2 OR, 3 XOR, 4 NOT, 5 SHL, 6 SHR, 7 SCR, 8 CMP, 9 ADD, 10 SUB, 11 INC, 12 DEC, 13–15 reserved.
- in_a, in_b  in  DATA_W  operands.
- in_tag  in  TAG_W  destination tag.
- alu_op_a, alu_op_b  out  DATA_W  to ALU op_a/op_b.
- alu_op_code  out  4  to ALU op_code.
- alu_out  in  DATA_W  ALU result (combinational from alu_* outputs).
- alu_flag_carry, alu_flag_overflow, alu_flag_parity, alu_flag_neg  in  1  ALU flags.
- out_valid  out  1  result valid to writeback.
- out_ready  in  1  writeback accepts.
- out_result  out  DATA_W  captured ALU result.
- out_tag  out  TAG_W  tag of the result.
- out_carry  out  1  architectural carry after this op.
- out_overflow, out_parity, out_neg  out  1  ALU flags captured with the result.

## Operation
- S1 (issue register): s1_valid, op, a, b, tag. It drives the alu_* outputs directly from registers.
- When s1_valid=0: alu_op_code=0, alu_op_a=0, alu_op_b=0. This is the NOP, and it quiets the ALU.
- S2 (result register): out_valid, result, tag, flags.
- Dropped ops: opcodes 0, 13, 14 and 15 occupy S1 for one cycle and never enter S2. They produce no output and do not change the carry flag.
- s1_adv = s1_valid & (s1_drop | !out_valid | out_ready).
- in_ready = !s1_valid | s1_adv. This is combinational; there is no in_valid→in_ready path.
- Accept (in_valid & in_ready): load S1 from in_*, s1_valid=1. Otherwise, if s1_adv, s1_valid=0.
- On s1_adv with a non-dropped op:
  - Load S2 from alu_out and the alu flags, with out_tag=S1 tag and out_valid=1.
  - Carry register: for op 9/10, carry_q←alu_flag_carry and out_carry←alu_flag_carry. Otherwise carry_q is unchanged and out_carry←carry_q.
- On out_valid & out_ready with no S2 load the same cycle: out_valid←0.
- Simultaneous S2 drain and S2 load: the load wins, out_valid stays 1, and the new data replaces the old. This gives full throughput.
- Ordering: results leave in acceptance order. There is no reordering and no forwarding.
- Reset mid-operation (reset_n=0 at an edge):
  - In-flight S1/S2 contents are discarded.
  - carry_q=0.
  - in_ready is 1 on the first cycle after reset is released.

## Timing
- Reset values:
  - out_valid=0 and s1_valid=0.
  - out_result, out_tag and all out_* flags = 0.
  - alu_op_a, alu_op_b and alu_op_code = 0.
  - in_ready=1.
- Latency: a request accepted at the edge ending cycle 0 drives the ALU during cycle 1, and out_valid=1 during cycle 2.
- Throughput: 1 op/cycle while out_ready=1.
- Backpressure: with out_ready=0 and S2 full, one more op can sit in S1. After that, in_ready=0.
- Handshake stability: while out_valid=1 and out_ready=0, all out_* signals hold stable.
- The ALU path is combinational within one cycle, from S1 registers to S2 capture.

## Test plan
- Single ADD: op=9, a=0xFFFFFFFF, b=1, tag=3 accepted in cycle 0 -> cycle 2: out_valid=1, out_result=0, out_carry=1, out_tag=3.
- Carry persistence: ADD producing carry=1, then AND a=0xF0F0F0F0, b=0xFF00FF00 -> AND result 0xF000F000 with out_carry=1. A following SUB that gives ALU carry 0 -> out_carry=0.
- Back-to-back stream: 8 XORs on consecutive cycles with out_ready=1 -> 8 results on consecutive cycles starting cycle 2, in order, with no bubbles.
- Backpressure: hold out_ready=0 after the first result -> the second op holds in S1 and in_ready=0. The third in_valid is not accepted until out_ready=1, and the outputs stay stable throughout.
- Dropped ops: stream ADD, NOP, op 14, OR -> exactly two results (ADD then OR) with tags preserved. carry_q is unchanged by the NOP and op 14. During the NOP's S1 cycle, alu_op_code=0.
- Reset mid-stream: assert reset_n=0 for one edge while S1 and S2 are both valid -> the next cycle shows out_valid=0, in_ready=1 and carry_q=0, and the discarded results are never presented.

Source files
------------

// File: rtl/alu_dispatch.sv
// Two-stage issue/capture front end for the 32-bit ALU: S1 drives the ALU, S2 captures result, flags and tag.
// Latency 2 cycles accept-to-out_valid; full throughput; with S2 stalled, one more op parks in S1, then in_ready drops.
module alu_dispatch #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [DATA_W-1:0] alu_op_a,
  output logic [DATA_W-1:0] alu_op_b,
  output logic [3:0]        alu_op_code,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_flag_carry,
  input  logic              alu_flag_overflow,
  input  logic              alu_flag_parity,
  input  logic              alu_flag_neg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_carry,
  output logic              out_overflow,
  output logic              out_parity,
  output logic              out_neg
);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd9;
  localparam logic [3:0] OP_SUB = 4'd10;
  localparam logic [3:0] OP_RSV = 4'd13;

  typedef struct packed {
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  tag;
  } req_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [TAG_W-1:0]  tag;
    logic              carry;
    logic              overflow;
    logic              parity;
    logic              neg;
  } res_t;

  logic s1_valid;
  req_t s1_q;
  res_t s2_q;
  logic carry_q;

  logic s1_drop;
  logic s1_adv;
  logic s2_load;
  logic is_addsub;
  logic accept;

  assign s1_drop   = (s1_q.op == OP_NOP) || (s1_q.op >= OP_RSV);
  assign s1_adv    = s1_valid && (s1_drop || !out_valid || out_ready);
  assign in_ready  = !s1_valid || s1_adv;
  assign accept    = in_valid && in_ready;
  assign s2_load   = s1_adv && !s1_drop;
  assign is_addsub = (s1_q.op == OP_ADD) || (s1_q.op == OP_SUB);

  // S1 payload is zeroed whenever it empties so the ALU sees a quiet NOP.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_q     <= '{op: in_op, a: in_a, b: in_b, tag: in_tag};
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end
  end

  // A load in the same cycle as a drain wins, keeping out_valid high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      s2_q      <= '0;
      carry_q   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      s2_q      <= '{result:   alu_out,
                     tag:      s1_q.tag,
                     carry:    is_addsub ? alu_flag_carry : carry_q,
                     overflow: alu_flag_overflow,
                     parity:   alu_flag_parity,
                     neg:      alu_flag_neg};
      if (is_addsub) carry_q <= alu_flag_carry;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign alu_op_code  = s1_q.op;
  assign alu_op_a     = s1_q.a;
  assign alu_op_b     = s1_q.b;

  assign out_result   = s2_q.result;
  assign out_tag      = s2_q.tag;
  assign out_carry    = s2_q.carry;
  assign out_overflow = s2_q.overflow;
  assign out_parity   = s2_q.parity;
  assign out_neg      = s2_q.neg;

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: behavioural ALU, in-order result scoreboard, directed and random traffic.
module tb_alu_dispatch;
  localparam int DW = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [3:0]    in_op, alu_op_code;
  logic [DW-1:0] in_a, in_b, alu_op_a, alu_op_b, alu_out, out_result;
  logic [TW-1:0] in_tag, out_tag;
  logic          alu_flag_carry, alu_flag_overflow, alu_flag_parity, alu_flag_neg;
  logic          out_carry, out_overflow, out_parity, out_neg;

  always #5 clk = ~clk;

  alu_dispatch #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_code(alu_op_code),
    .alu_out(alu_out), .alu_flag_carry(alu_flag_carry),
    .alu_flag_overflow(alu_flag_overflow), .alu_flag_parity(alu_flag_parity),
    .alu_flag_neg(alu_flag_neg),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_carry(out_carry), .out_overflow(out_overflow),
    .out_parity(out_parity), .out_neg(out_neg)
  );

  typedef struct packed {
    logic [31:0] res;
    logic c, v, p, n;
  } alu_t;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tag;
    logic c, v, p, n;
  } exp_t;

  // Stand-in ALU; non-ADD/SUB ops emit a data-dependent carry the block must ignore.
  function automatic alu_t alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_t r;
    logic [32:0] w;
    int sh;
    r = '0;
    sh = int'(b[4:0]);
    case (op)
      4'd1:  r.res = a & b;
      4'd2:  r.res = a | b;
      4'd3:  r.res = a ^ b;
      4'd4:  r.res = ~a;
      4'd5:  r.res = a << sh;
      4'd6:  r.res = a >> sh;
      4'd7:  r.res = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
      4'd8:  r.res = (a < b) ? 32'd1 : 32'd0;
      4'd9: begin
        w = {1'b0, a} + {1'b0, b};
        r.res = w[31:0]; r.c = w[32];
        r.v = (a[31] == b[31]) && (r.res[31] != a[31]);
      end
      4'd10: begin
        w = {1'b0, a} - {1'b0, b};
        r.res = w[31:0]; r.c = w[32];
        r.v = (a[31] != b[31]) && (r.res[31] != a[31]);
      end
      4'd11: r.res = a + 32'd1;
      4'd12: r.res = a - 32'd1;
      default: r.res = 32'hDEAD_BEEF;
    endcase
    if (op != 4'd9 && op != 4'd10) r.c = a[0] ^ b[1];
    r.p = ^r.res;
    r.n = r.res[31];
    return r;
  endfunction

  alu_t alu_r;
  assign alu_r             = alu_model(alu_op_code, alu_op_a, alu_op_b);
  assign alu_out           = alu_r.res;
  assign alu_flag_carry    = alu_r.c;
  assign alu_flag_overflow = alu_r.v;
  assign alu_flag_parity   = alu_r.p;
  assign alu_flag_neg      = alu_r.n;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  exp_t q[$];
  exp_t got[$];
  int pop_cycles[$];
  logic m_carry = 1'b0;
  logic prev_stall = 1'b0;
  exp_t prev_out;
  logic acc_prev = 1'b0;
  logic [3:0] p_op;
  logic [31:0] p_a, p_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, sample #1 later, then update the model with what the next edge will do.
  task automatic cyc(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] tag, input logic ordy);
    exp_t cur;
    alu_t al;
    @(negedge clk);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = ordy;
    #1;
    cyc_n++;
    cur = '{res: out_result, tag: out_tag, c: out_carry, v: out_overflow, p: out_parity, n: out_neg};
    if (acc_prev) begin
      chk("alu_op_code", alu_op_code, p_op);
      chk("alu_op_a", alu_op_a, p_a);
      chk("alu_op_b", alu_op_b, p_b);
    end
    if (prev_stall) begin
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_stable", cur, prev_out);
    end
    if (out_valid) chk("out_has_model_entry", q.size() > 0, 1'b1);
    if (out_valid && q.size() > 0) begin
      chk("out_data", cur, q[0]);
      if (ordy) begin
        void'(q.pop_front());
        got.push_back(cur);
        pop_cycles.push_back(cyc_n);
      end
    end
    prev_stall = out_valid && !ordy;
    prev_out = cur;
    acc_prev = v && in_ready;
    if (acc_prev) begin
      p_op = op; p_a = a; p_b = b;
      if (op >= 4'd1 && op <= 4'd12) begin
        al = alu_model(op, a, b);
        if (op == 4'd9 || op == 4'd10) m_carry = al.c;
        q.push_back('{res: al.res, tag: tag, c: m_carry, v: al.v, p: al.p, n: al.n});
      end
    end
  endtask

  task automatic do_reset(input int edges);
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (edges) @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    m_carry = 1'b0; prev_stall = 1'b0; acc_prev = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", out_tag, 5'd0);
    chk("rst_out_flags", {out_carry, out_overflow, out_parity, out_neg}, 4'd0);
    chk("rst_alu_code", alu_op_code, 4'd0);
    chk("rst_alu_a", alu_op_a, 32'd0);
    chk("rst_alu_b", alu_op_b, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) cyc(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);
    chk("drain_empty", q.size(), 0);
    repeat (2) cyc(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);
  endtask

  initial begin
    int s;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    do_reset(2);

    // Single ADD: latency and carry out.
    cyc(1'b1, 4'd9, 32'hFFFF_FFFF, 32'd1, 5'd3, 1'b1);
    chk("add_accepted", acc_prev, 1'b1);
    cyc(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);
    chk("add_lat_cycle1", out_valid, 1'b0);
    cyc(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);
    chk("add_lat_cycle2", out_valid, 1'b1);
    chk("add_result", out_result, 32'd0);
    chk("add_carry", out_carry, 1'b1);
    chk("add_tag", out_tag, 5'd3);
    drain();

    // Carry persists through AND, cleared by a borrow-free SUB.
    got.delete();
    cyc(1'b1, 4'd9, 32'hFFFF_FFFF, 32'd1, 5'd1, 1'b1);
    cyc(1'b1, 4'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd2, 1'b1);
    cyc(1'b1, 4'd10, 32'd5, 32'd3, 5'd4, 1'b1);
    drain();
    chk("carry_cnt", got.size(), 3);
    if (got.size() == 3) begin
      chk("carry_and_res", got[1].res, 32'hF000_F000);
      chk("carry_and_c", got[1].c, 1'b1);
      chk("carry_sub_c", got[2].c, 1'b0);
    end

    // Back-to-back XOR stream.
    got.delete(); pop_cycles.delete();
    s = cyc_n + 1;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 4'd3, $urandom, $urandom, 5'(i + 16), 1'b1);
      chk("stream_accept", acc_prev, 1'b1);
    end
    drain();
    chk("stream_cnt", pop_cycles.size(), 8);
    for (int i = 0; i < 8 && i < pop_cycles.size(); i++) chk("stream_cycle", pop_cycles[i], s + 2 + i);

    // Backpressure: S2 and S1 fill, third op waits for out_ready.
    got.delete();
    cyc(1'b1, 4'd9, 32'h7FFF_FFFF, 32'd1, 5'd20, 1'b0);
    cyc(1'b1, 4'd2, 32'h1234_0000, 32'h0000_5678, 5'd21, 1'b0);
    chk("bp_second_accept", acc_prev, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 4'd3, 32'hAAAA_5555, 32'h0F0F_0F0F, 5'd22, 1'b0);
      chk("bp_in_ready_low", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
    end
    cyc(1'b1, 4'd3, 32'hAAAA_5555, 32'h0F0F_0F0F, 5'd22, 1'b1);
    chk("bp_third_accept", acc_prev, 1'b1);
    drain();
    chk("bp_cnt", got.size(), 3);
    if (got.size() == 3) chk("bp_order", {got[0].tag, got[1].tag, got[2].tag}, {5'd20, 5'd21, 5'd22});

    // Dropped ops: NOP and reserved 14 leave no result and keep carry.
    got.delete();
    cyc(1'b1, 4'd9, 32'h8000_0000, 32'h8000_0000, 5'd7, 1'b1);
    cyc(1'b1, 4'd0, 32'h1, 32'h2, 5'd8, 1'b1);
    cyc(1'b1, 4'd14, 32'h2, 32'h0, 5'd9, 1'b1);
    chk("drop_nop_alu_code", alu_op_code, 4'd0);
    cyc(1'b1, 4'd2, 32'h2, 32'h0, 5'd10, 1'b1);
    drain();
    chk("drop_cnt", got.size(), 2);
    if (got.size() == 2) begin
      chk("drop_tags", {got[0].tag, got[1].tag}, {5'd7, 5'd10});
      chk("drop_carry_kept", got[1].c, 1'b1);
    end

    // Reset with both stages full.
    got.delete();
    cyc(1'b1, 4'd9, 32'hFFFF_FFFF, 32'd2, 5'd11, 1'b0);
    cyc(1'b1, 4'd1, 32'h1, 32'h2, 5'd12, 1'b0);
    do_reset(1);
    cyc(1'b1, 4'd1, 32'h1, 32'h0, 5'd13, 1'b1);
    drain();
    chk("rst_mid_cnt", got.size(), 1);
    if (got.size() == 1) begin
      chk("rst_mid_tag", got[0].tag, 5'd13);
      chk("rst_mid_carry", got[0].c, 1'b0);
    end

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom, $urandom,
          5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
